ram_fifo_ctrl: RTL

- FIFO controller that sits directly upstream of the 64x8 single-port `ram` block. It generates `ram`'s `data`, `addr` and `we`, and consumes `ram`'s `q`.
- It turns that single port into a valid/ready push/pop FIFO, using one RAM access per cycle with reads taking priority.
- A one-word output register holds the head of the queue for the consumer.
- The parent module instantiates `ram` and `ram_fifo_ctrl` side by side.

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_fifo_ctrl.sv | 90 +++++++++
 2 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the 64x8 single-port RAM and its FIFO controller.
package ram_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 6;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;

  // Read-side sequencing: idle, or one RAM read in flight awaiting capture.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RDW  = 1'b1
  } fsm_t;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO built on a single-port RAM with 1-cycle read latency.
// One RAM access per cycle; reads win over writes. The head word lives in a
// one-deep output register so the RAM port is free while the consumer stalls.
module ram_fifo_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_W = ram_pkg::DEF_DATA_W,
  parameter int ADDR_W = ram_pkg::DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   fill,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int            FIFO_DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL     = (ADDR_W + 1)'(FIFO_DEPTH);

  fsm_t              state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              rd_issue;

  assign fill = cnt;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: an issued read is always captured on the following edge
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (rd_issue) state_nxt = S_RDW;
      S_RDW:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs / RAM port arbitration: refill the empty head first, else write
  always_comb begin
    rd_issue = (state == S_IDLE) && !out_valid && (cnt != '0);
    in_ready = (cnt != FULL) && !rd_issue && rst_n;
    ram_we   = in_valid && in_ready;
    ram_addr = rd_issue ? rd_ptr : wr_ptr;
    ram_data = in_data;
  end

  // Pointers and occupancy; write and read-issue are mutually exclusive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (ram_we)   wr_ptr <= wr_ptr + 1'b1;
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      case ({ram_we, rd_issue})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Output register: capture the RAM word one cycle after issue, clear on pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (state == S_RDW) begin
      out_valid <= 1'b1;
      out_data  <= ram_q;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
